// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types and defaults for the CORDIC request scheduler
//
// Contents:
//   sched_state_e           2-bit scheduler state encoding
//   DEFAULT_DATA_WIDTH      width of x, y, magnitude and angle
//   DEFAULT_ITERATION_WIDTH width of the iteration-count field
//   DEFAULT_TIMEOUT_CYCLES  BUSY cycle budget before an operation is aborted
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RESPOND = 2'd3
    } sched_state_e;

    localparam int DEFAULT_DATA_WIDTH      = 16;
    localparam int DEFAULT_ITERATION_WIDTH = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 64;

endpackage

// File: rtl/cordic_req_scheduler_rr_arbiter.sv
// rtl/cordic_req_scheduler_rr_arbiter.sv - combinational round-robin arbiter
//
// Ports:
//   req      in   NUM_REQ          request vector
//   ptr      in   clog2(NUM_REQ)   highest-priority index
//   grant    out  NUM_REQ          one-hot grant (all zero when no request)
//   idx      out  clog2(NUM_REQ)   encoded grant index
//   any_req  out  1                some request bit is set
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any_req
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    // Scan from ptr upwards, wrapping; the first set bit wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any_req && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                any_req     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_req_scheduler.sv
// rtl/cordic_req_scheduler.sv - shares one CORDIC vectoring core among NUM_REQ requesters
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/req_ready       per-requester request handshake (ready is one-hot grant)
//   req_x/req_y/req_n         packed operands, slice i belongs to requester i
//   core_start                one-cycle start pulse to the core
//   core_x/core_y/core_n      latched operands
//   core_done/mag/angle       core completion and results
//   resp_valid/resp_ready     one-hot response handshake to the owner
//   resp_mag/resp_angle       held results
//   resp_err                  response is a timeout abort
//   spurious_done             sticky: core_done seen outside BUSY
module cordic_req_scheduler
    import cordic_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int ITERATION_WIDTH = DEFAULT_ITERATION_WIDTH,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_y,
    input  logic [NUM_REQ*ITERATION_WIDTH-1:0] req_n,
    output logic                               core_start,
    output logic [DATA_WIDTH-1:0]              core_x,
    output logic [DATA_WIDTH-1:0]              core_y,
    output logic [ITERATION_WIDTH-1:0]         core_n,
    input  logic                               core_done,
    input  logic [DATA_WIDTH-1:0]              core_mag,
    input  logic [DATA_WIDTH-1:0]              core_angle,
    output logic [NUM_REQ-1:0]                 resp_valid,
    input  logic [NUM_REQ-1:0]                 resp_ready,
    output logic [DATA_WIDTH-1:0]              resp_mag,
    output logic [DATA_WIDTH-1:0]              resp_angle,
    output logic                               resp_err,
    output logic                               spurious_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    // The counter is cleared in ISSUE and reaches TIMEOUT_CYCLES-1 on the edge
    // leaving the last BUSY cycle, so the abort response appears exactly
    // TIMEOUT_CYCLES cycles after ISSUE.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    sched_state_e               state_q, state_d;
    logic [IDX_W-1:0]           ptr_q, ptr_d;
    logic [IDX_W-1:0]           owner_q, owner_d;
    logic [DATA_WIDTH-1:0]      core_x_q, core_x_d;
    logic [DATA_WIDTH-1:0]      core_y_q, core_y_d;
    logic [ITERATION_WIDTH-1:0] core_n_q, core_n_d;
    logic [DATA_WIDTH-1:0]      resp_mag_q, resp_mag_d;
    logic [DATA_WIDTH-1:0]      resp_angle_q, resp_angle_d;
    logic                       resp_err_q, resp_err_d;
    logic [NUM_REQ-1:0]         resp_valid_q, resp_valid_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       spurious_q, spurious_d;

    logic [NUM_REQ-1:0]         grant;
    logic [IDX_W-1:0]           grant_idx;
    logic                       any_req;
    logic [NUM_REQ-1:0]         owner_onehot;

    logic [DATA_WIDTH-1:0]      x_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]      y_arr [NUM_REQ];
    logic [ITERATION_WIDTH-1:0] n_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign x_arr[g] = req_x[g*DATA_WIDTH +: DATA_WIDTH];
        assign y_arr[g] = req_y[g*DATA_WIDTH +: DATA_WIDTH];
        assign n_arr[g] = req_n[g*ITERATION_WIDTH +: ITERATION_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .grant   (grant),
        .idx     (grant_idx),
        .any_req (any_req)
    );

    assign owner_onehot = NUM_REQ'(1) << owner_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        core_x_d     = core_x_q;
        core_y_d     = core_y_q;
        core_n_d     = core_n_q;
        resp_mag_d   = resp_mag_q;
        resp_angle_d = resp_angle_q;
        resp_err_d   = resp_err_q;
        resp_valid_d = resp_valid_q;
        cnt_d        = cnt_q;
        spurious_d   = spurious_q;
        req_ready    = '0;
        core_start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Gated by rst so the grant is not visible while reset is held.
                if (any_req && rst) begin
                    req_ready = grant;
                    core_x_d  = x_arr[grant_idx];
                    core_y_d  = y_arr[grant_idx];
                    core_n_d  = n_arr[grant_idx];
                    owner_d   = grant_idx;
                    ptr_d     = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_start = 1'b1;
                cnt_d      = '0;
                state_d    = ST_BUSY;
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // done takes priority over a coincident timeout
                if (core_done) begin
                    resp_mag_d   = core_mag;
                    resp_angle_d = core_angle;
                    resp_err_d   = 1'b0;
                    resp_valid_d = owner_onehot;
                    state_d      = ST_RESPOND;
                end else if (cnt_q == CNT_LAST) begin
                    resp_mag_d   = '0;
                    resp_angle_d = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = owner_onehot;
                    state_d      = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (resp_ready[owner_q]) begin
                    resp_valid_d = '0;
                    resp_err_d   = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (core_done && state_q != ST_BUSY) begin
            spurious_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            core_x_q     <= '0;
            core_y_q     <= '0;
            core_n_q     <= '0;
            resp_mag_q   <= '0;
            resp_angle_q <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= '0;
            cnt_q        <= '0;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            core_x_q     <= core_x_d;
            core_y_q     <= core_y_d;
            core_n_q     <= core_n_d;
            resp_mag_q   <= resp_mag_d;
            resp_angle_q <= resp_angle_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= resp_valid_d;
            cnt_q        <= cnt_d;
            spurious_q   <= spurious_d;
        end
    end

    assign core_x        = core_x_q;
    assign core_y        = core_y_q;
    assign core_n        = core_n_q;
    assign resp_valid    = resp_valid_q;
    assign resp_mag      = resp_mag_q;
    assign resp_angle    = resp_angle_q;
    assign resp_err      = resp_err_q;
    assign spurious_done = spurious_q;

endmodule
